anton_neopixel_sequencer: RTL and testbench

Frame sequencer for the NeoPixel stream datapath. It generates `state`, `pixelIndex`, `pixelBitIndex` and `bitPatternIndex` so the stream block walks the pixel buffer one bit-pattern slot per clock. Between frames it enforces the strip's low "latch" period. It supports one-shot and looped refresh in 8-bit and 32-bit buffer modes, and flags frame completion to the register/bus side.

---
 rtl/anton_neopixel_sequencer.sv | 153 +++++++++++++++
 tb/tb_anton_neopixel_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: walks pixel/bit/slot indices one slot per clock, then holds the latch period.
// All outputs registered (start latency 1 clock after a run rising edge); no backpressure, run low aborts.
module anton_neopixel_sequencer #(
  parameter int  BUFFER_END   = 26,
  parameter int  RESET_CYCLES = 400,
  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regMax,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   streamSync,
  output logic                   busy
);

  localparam logic ENUM_STATE_TRANSMIT = 1'b1;
  localparam logic ENUM_STATE_RESET    = 1'b0;
  localparam int   LATCH_BITS          = $clog2(RESET_CYCLES + 1);
  localparam logic [LATCH_BITS-1:0]  LATCH_LAST = LATCH_BITS'(RESET_CYCLES - 1);
  localparam logic [BUFFER_BITS-1:0] END_IDX    = BUFFER_BITS'(BUFFER_END);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_LATCH} fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic                   state_q, state_d;
  logic [BUFFER_BITS-1:0] pixel_index_q, pixel_index_d;
  logic [4:0]             pixel_bit_q, pixel_bit_d;
  logic [2:0]             bit_pattern_q, bit_pattern_d;
  logic                   stream_sync_q, stream_sync_d;
  logic                   busy_q, busy_d;
  logic                   run_prev_q, run_prev_d;
  logic [LATCH_BITS-1:0]  latch_cnt_q, latch_cnt_d;
  logic                   mode32_q, mode32_d;
  logic [BUFFER_BITS-1:0] max_q, max_d;

  logic                   run_rise;
  logic                   last_pixel;
  logic [BUFFER_BITS-1:0] step;
  logic                   start_frame;
  logic                   clear_cnt;

  assign run_rise   = regCtrlRun & ~run_prev_q;
  // In 32-bit mode the two byte-select bits of max are ignored.
  assign last_pixel = mode32_q ? ((pixel_index_q >> 2) == (max_q >> 2)) : (pixel_index_q == max_q);
  assign step       = mode32_q ? BUFFER_BITS'(4) : BUFFER_BITS'(1);

  always_comb begin
    fsm_d         = fsm_q;
    pixel_index_d = pixel_index_q;
    pixel_bit_d   = pixel_bit_q;
    bit_pattern_d = bit_pattern_q;
    stream_sync_d = 1'b0;
    run_prev_d    = regCtrlRun;
    latch_cnt_d   = latch_cnt_q;
    mode32_d      = mode32_q;
    max_d         = max_q;
    start_frame   = 1'b0;
    clear_cnt     = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (run_rise) start_frame = 1'b1;
      end
      S_TX: begin
        if (!regCtrlRun) begin
          fsm_d     = S_LATCH;
          clear_cnt = 1'b1;
        end else begin
          bit_pattern_d = bit_pattern_q + 3'd1;
          if (bit_pattern_q == 3'd7) begin
            if (pixel_bit_q == 5'd0) begin
              if (last_pixel) begin
                fsm_d         = S_LATCH;
                clear_cnt     = 1'b1;
                stream_sync_d = 1'b1;
              end else begin
                pixel_index_d = pixel_index_q + step;
                pixel_bit_d   = 5'd23;
              end
            end else begin
              pixel_bit_d = pixel_bit_q - 5'd1;
            end
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          if (regCtrlRun & regCtrlLoop) start_frame = 1'b1;
          else                          fsm_d       = S_IDLE;
          latch_cnt_d = '0;
        end else begin
          latch_cnt_d = latch_cnt_q + LATCH_BITS'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    if (start_frame) begin
      fsm_d     = S_TX;
      clear_cnt = 1'b1;
      mode32_d  = regCtrl32bit;
      max_d     = (regMax > END_IDX) ? END_IDX : regMax;
    end
    if (clear_cnt) begin
      pixel_index_d = '0;
      pixel_bit_d   = 5'd23;
      bit_pattern_d = 3'd0;
      latch_cnt_d   = '0;
    end
    state_d = (fsm_d == S_TX) ? ENUM_STATE_TRANSMIT : ENUM_STATE_RESET;
    busy_d  = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      fsm_q         <= S_IDLE;
      state_q       <= ENUM_STATE_RESET;
      pixel_index_q <= '0;
      pixel_bit_q   <= 5'd23;
      bit_pattern_q <= 3'd0;
      stream_sync_q <= 1'b0;
      busy_q        <= 1'b0;
      run_prev_q    <= 1'b0;
      latch_cnt_q   <= '0;
      mode32_q      <= 1'b0;
      max_q         <= '0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      pixel_index_q <= pixel_index_d;
      pixel_bit_q   <= pixel_bit_d;
      bit_pattern_q <= bit_pattern_d;
      stream_sync_q <= stream_sync_d;
      busy_q        <= busy_d;
      run_prev_q    <= run_prev_d;
      latch_cnt_q   <= latch_cnt_d;
      mode32_q      <= mode32_d;
      max_q         <= max_d;
    end
  end

  assign state           = state_q;
  assign pixelIndex      = pixel_index_q;
  assign pixelBitIndex   = pixel_bit_q;
  assign bitPatternIndex = bit_pattern_q;
  assign streamSync      = stream_sync_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Bench for anton_neopixel_sequencer: expected indices derived from the elapsed TX time of each frame.
module tb_anton_neopixel_sequencer;

  localparam int   BE  = 26;
  localparam int   RC  = 400;
  localparam int   BB  = $clog2(BE + 1);
  localparam logic TX  = 1'b1;
  localparam logic RST = 1'b0;

  logic          clk7mhz = 1'b0;
  logic          rstn = 1'b0;
  logic          run = 1'b0;
  logic          loop_r = 1'b0;
  logic          m32 = 1'b0;
  logic [BB-1:0] rmax = '0;
  logic          state;
  logic [BB-1:0] pixelIndex;
  logic [4:0]    pixelBitIndex;
  logic [2:0]    bitPatternIndex;
  logic          streamSync;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Mid-frame register writes applied at a chosen TX cycle.
  int            poke_at = -1;
  logic          poke_m32;
  logic [BB-1:0] poke_max;
  logic          poke_loop;

  anton_neopixel_sequencer #(.BUFFER_END(BE), .RESET_CYCLES(RC)) dut (
    .clk7mhz(clk7mhz), .rstn(rstn), .regCtrlRun(run), .regCtrlLoop(loop_r),
    .regCtrl32bit(m32), .regMax(rmax), .state(state), .pixelIndex(pixelIndex),
    .pixelBitIndex(pixelBitIndex), .bitPatternIndex(bitPatternIndex),
    .streamSync(streamSync), .busy(busy)
  );

  always #5 clk7mhz = ~clk7mhz;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string ph, input logic st, input int pi, input int pb,
                         input int bp, input logic sy, input logic bz);
    chk({ph, ".state"}, 32'(state), 32'(st));
    chk({ph, ".pixelIndex"}, 32'(pixelIndex), pi);
    chk({ph, ".pixelBitIndex"}, 32'(pixelBitIndex), pb);
    chk({ph, ".bitPatternIndex"}, 32'(bitPatternIndex), bp);
    chk({ph, ".streamSync"}, 32'(streamSync), 32'(sy));
    chk({ph, ".busy"}, 32'(busy), 32'(bz));
  endtask

  task automatic start_frame(input logic m, input logic [BB-1:0] mx, input logic lp);
    @(negedge clk7mhz);
    run = 1'b0;
    @(negedge clk7mhz);
    m32 = m; rmax = mx; loop_r = lp; run = 1'b1;
  endtask

  // Frame of npix pixels lasts npix*192 clocks; slot t maps to pixel t/192, bit 23-(t%192)/8, slot t%8.
  task automatic check_tx(input logic m, input int mx, input int stop_at, input bit abort);
    int eff, step, npix, len;
    eff  = (mx > BE) ? BE : mx;
    step = m ? 4 : 1;
    npix = m ? eff / 4 + 1 : eff + 1;
    len  = npix * 192;
    for (int t = 0; t < len; t++) begin
      @(negedge clk7mhz);
      exp_out("tx", TX, step * (t / 192), 23 - (t % 192) / 8, t % 8, 1'b0, 1'b1);
      if (t == poke_at) begin
        m32 = poke_m32; rmax = poke_max; loop_r = poke_loop;
      end
      if (t == stop_at) begin
        if (abort) run = 1'b0;
        return;
      end
    end
  endtask

  task automatic check_latch(input bit sync_exp, input bit to_idle, input int raise_at);
    for (int k = 0; k < RC; k++) begin
      @(negedge clk7mhz);
      exp_out("latch", RST, 0, 23, 0, (k == 0) && sync_exp, 1'b1);
      if (k == raise_at) run = 1'b1;
    end
    if (to_idle) begin
      @(negedge clk7mhz);
      exp_out("idle", RST, 0, 23, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int rm, rmx;
    // Reset state
    repeat (3) @(negedge clk7mhz);
    exp_out("reset", RST, 0, 23, 0, 1'b0, 1'b0);
    rstn = 1'b1;
    @(negedge clk7mhz);
    exp_out("idle0", RST, 0, 23, 0, 1'b0, 1'b0);

    // 8-bit one-shot, three pixels
    start_frame(1'b0, BB'(2), 1'b0);
    check_tx(1'b0, 2, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);

    // 32-bit mode: max 11 and max 10 both give pixels 0,4,8
    start_frame(1'b1, BB'(11), 1'b0);
    check_tx(1'b1, 11, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);
    start_frame(1'b1, BB'(10), 1'b0);
    check_tx(1'b1, 10, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);

    // Looped refresh with a mode/max change that must wait for the next frame
    start_frame(1'b0, BB'(0), 1'b1);
    check_tx(1'b0, 0, -1, 1'b0);
    check_latch(1'b1, 1'b0, -1);
    poke_at = 50; poke_m32 = 1'b1; poke_max = BB'(4); poke_loop = 1'b1;
    check_tx(1'b0, 0, -1, 1'b0);
    check_latch(1'b1, 1'b0, -1);
    poke_at = 100; poke_loop = 1'b0;
    check_tx(1'b1, 4, -1, 1'b0);
    poke_at = -1;
    check_latch(1'b1, 1'b1, -1);

    // Abort at TX cycle 100, run re-raised during latch is ignored
    start_frame(1'b0, BB'(5), 1'b0);
    check_tx(1'b0, 5, 100, 1'b1);
    check_latch(1'b0, 1'b1, 10);
    repeat (5) begin
      @(negedge clk7mhz);
      exp_out("idle_hold", RST, 0, 23, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-frame with run held high
    start_frame(1'b0, BB'(5), 1'b0);
    check_tx(1'b0, 5, 3 * 192 + 20, 1'b0);
    #2 rstn = 1'b0;
    #1 exp_out("async_rst", RST, 0, 23, 0, 1'b0, 1'b0);
    @(negedge clk7mhz);
    @(negedge clk7mhz);
    rstn = 1'b1;
    check_tx(1'b0, 5, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);

    // Max beyond the buffer is clipped to the last buffer byte
    start_frame(1'b0, BB'(BE + 5), 1'b0);
    check_tx(1'b0, BE + 5, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);
    start_frame(1'b1, BB'(BE + 5), 1'b0);
    check_tx(1'b1, BE + 5, -1, 1'b0);
    check_latch(1'b1, 1'b1, -1);

    // Randomised one-shot frames
    for (int i = 0; i < 3; i++) begin
      rm  = int'($urandom_range(0, 1));
      rmx = int'($urandom_range(0, 12));
      start_frame(rm[0], BB'(rmx), 1'b0);
      check_tx(rm[0], rmx, -1, 1'b0);
      check_latch(1'b1, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
